pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Generates write-enables and bubble/flush

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs and pipeline-register strobes.
// The pipeline drives the master side; the controller is the slave.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic              ex_memread;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_br_taken;
   logic              ex_mdu_start;
   logic              mem_req;
   logic              mem_ready;
   logic              pc_wr;
   logic              ifid_wr;
   logic              ifid_flush;
   logic              idex_wr;
   logic              idex_flush;
   logic              exmem_wr;
   logic              exmem_flush;
   logic              mdu_busy;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_rd, ex_br_taken,
             ex_mdu_start, mem_req, mem_ready,
      input  pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, exmem_flush,
             mdu_busy, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_rd, ex_br_taken,
             ex_mdu_start, mem_req, mem_ready,
      output pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, exmem_flush,
             mdu_busy, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// multi-cycle MDU occupancy of EX and data-memory wait states.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MDU_LAT = 4,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int unsigned MdcW = $clog2(MDU_LAT + 1);
   localparam logic [MdcW-1:0] MdcInit = (MDU_LAT >= 2) ? MdcW'(MDU_LAT - 2) : '0;

   typedef enum logic [0:0] {StRun, StMduBusy} state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [MdcW-1:0]   r_mdu_cnt;
   logic [MdcW-1:0]   w_mdu_cnt_d;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_mem_wait;
   logic w_load_use;
   logic w_pc_wr;
   logic w_ifid_wr;
   logic w_ifid_flush;
   logic w_idex_wr;
   logic w_idex_flush;
   logic w_exmem_wr;
   logic w_exmem_flush;

   assign w_mem_wait = bus.mem_req & ~bus.mem_ready;
   assign w_load_use = bus.ex_memread & (bus.ex_rd != REG_AW'(0)) &
                       ((bus.id_use_rs & (bus.id_rs == bus.ex_rd)) |
                        (bus.id_use_rt & (bus.id_rt == bus.ex_rd)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StRun;
         r_mdu_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state   <= w_state_d;
         r_mdu_cnt <= w_mdu_cnt_d;
         if (!w_pc_wr) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_mdu_cnt_d   = r_mdu_cnt;
      w_pc_wr       = 1'b1;
      w_ifid_wr     = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_wr     = 1'b1;
      w_idex_flush  = 1'b0;
      w_exmem_wr    = 1'b1;
      w_exmem_flush = 1'b0;
      if (!rst || w_mem_wait) begin
         // Reset or memory wait: everything frozen, state and counter hold.
         w_pc_wr    = 1'b0;
         w_ifid_wr  = 1'b0;
         w_idex_wr  = 1'b0;
         w_exmem_wr = 1'b0;
      end else if (r_state == StMduBusy) begin
         w_pc_wr       = 1'b0;
         w_ifid_wr     = 1'b0;
         w_idex_wr     = 1'b0;
         w_exmem_flush = 1'b1;
         if (r_mdu_cnt == '0) begin
            w_state_d = StRun;
         end else begin
            w_mdu_cnt_d = r_mdu_cnt - MdcW'(1);
         end
      end else if (bus.ex_mdu_start) begin
         w_pc_wr       = 1'b0;
         w_ifid_wr     = 1'b0;
         w_idex_wr     = 1'b0;
         w_exmem_flush = 1'b1;
         // The start cycle is itself the first of MDU_LAT stall cycles.
         if (MDU_LAT > 1) begin
            w_state_d   = StMduBusy;
            w_mdu_cnt_d = MdcInit;
         end
      end else if (bus.ex_br_taken) begin
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if (w_load_use) begin
         w_pc_wr      = 1'b0;
         w_ifid_wr    = 1'b0;
         w_idex_flush = 1'b1;
      end
   end

   assign bus.pc_wr       = w_pc_wr;
   assign bus.ifid_wr     = w_ifid_wr;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.idex_wr     = w_idex_wr;
   assign bus.idex_flush  = w_idex_flush;
   assign bus.exmem_wr    = w_exmem_wr;
   assign bus.exmem_flush = w_exmem_flush;
   assign bus.mdu_busy    = (r_state == StMduBusy);
   assign bus.stall_cnt   = r_stall_cnt;
endmodule
